// File: rtl/crypto_stream_bridge.sv
// Avalon-MM slave that moves host word traffic to and from a block cipher core
// through an input block FIFO and an output block FIFO, with credit-limited issue.
module crypto_stream_bridge #(
  parameter int unsigned DATAWIDTH          = 32,
  parameter int unsigned BLOCKWIDTH         = 64,
  parameter int unsigned IN_DEPTH           = 16,
  parameter int unsigned OUT_DEPTH          = 16,
  parameter int unsigned MAX_INFLIGHT       = 4,
  parameter int unsigned SLAVE_ADDRESSWIDTH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0] slave_address,
  input  logic                          slave_chipselect,
  input  logic                          slave_write,
  input  logic [DATAWIDTH-1:0]          slave_writedata,
  input  logic                          slave_read,
  output logic [DATAWIDTH-1:0]          slave_readdata,
  output logic [BLOCKWIDTH-1:0]         core_data_in,
  output logic                          core_valid_in,
  input  logic                          core_ready,
  output logic                          core_is_encrypt,
  input  logic [BLOCKWIDTH-1:0]         core_data_out,
  input  logic                          core_valid_out,
  output logic                          irq
);

  localparam int unsigned WPB = BLOCKWIDTH / DATAWIDTH;
  localparam int unsigned WIW = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned IPW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned ICW = $clog2(IN_DEPTH + 1);
  localparam int unsigned OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned OCW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned FW  = $clog2(MAX_INFLIGHT + 1);

  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_CTRL      = SLAVE_ADDRESSWIDTH'(0);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STATUS    = SLAVE_ADDRESSWIDTH'(1);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_IN_COUNT  = SLAVE_ADDRESSWIDTH'(2);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_OUT_COUNT = SLAVE_ADDRESSWIDTH'(3);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_IN_DATA   = SLAVE_ADDRESSWIDTH'(4);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_OUT_DATA  = SLAVE_ADDRESSWIDTH'(5);

  logic [BLOCKWIDTH-1:0] in_mem  [IN_DEPTH];
  logic [BLOCKWIDTH-1:0] out_mem [OUT_DEPTH];

  logic                  en_q, en_d, mode_q, mode_d, irq_en_q, irq_en_d;
  logic                  flush_q, flush_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [BLOCKWIDTH-1:0] in_shift_q, in_shift_d;
  logic [WIW-1:0]        in_idx_q, in_idx_d, out_idx_q, out_idx_d;
  logic [IPW-1:0]        in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [ICW-1:0]        in_cnt_q, in_cnt_d;
  logic [OPW-1:0]        out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [OCW-1:0]        out_cnt_q, out_cnt_d;
  logic [FW-1:0]         inflight_q, inflight_d;
  logic [DATAWIDTH-1:0]  readdata_q, readdata_d;
  logic [BLOCKWIDTH-1:0] core_data_q, core_data_d;
  logic                  core_valid_q, core_valid_d, irq_q, irq_d;

  logic wr_c, rd_c, wr_ctrl_c, wr_status_c, wr_in_c, rd_out_c;
  logic in_full_c, in_empty_c, out_full_c, out_empty_c, busy_c;
  logic flush_req_c, ret_c, credit_c, issue_c, in_last_c, out_last_c;
  logic in_push_c, out_pop_c, out_push_c, flush_done_c, unused_c;
  logic [FW-1:0]         inflight_nxt_c;
  logic [BLOCKWIDTH-1:0] in_shifted_c, out_head_c;
  logic [DATAWIDTH-1:0]  out_word_c;

  // Bus decode; a write wins over a simultaneous read
  assign wr_c        = slave_chipselect & slave_write;
  assign rd_c        = slave_chipselect & slave_read & ~slave_write;
  assign wr_ctrl_c   = wr_c & (slave_address == A_CTRL);
  assign wr_status_c = wr_c & (slave_address == A_STATUS);
  assign wr_in_c     = wr_c & (slave_address == A_IN_DATA);
  assign rd_out_c    = rd_c & (slave_address == A_OUT_DATA);
  assign unused_c    = ^slave_writedata;

  assign in_full_c   = (in_cnt_q == ICW'(IN_DEPTH));
  assign in_empty_c  = (in_cnt_q == '0);
  assign out_full_c  = (out_cnt_q == OCW'(OUT_DEPTH));
  assign out_empty_c = (out_cnt_q == '0);
  assign busy_c      = (inflight_q != '0);

  // Issue is blocked from the cycle the flush request is written
  assign flush_req_c = flush_q | (wr_ctrl_c & slave_writedata[1]);
  // A result with nothing outstanding (e.g. left over from before reset) is ignored
  assign ret_c       = core_valid_out & busy_c;
  assign credit_c    = (32'(out_cnt_q) + 32'(inflight_q)) < 32'(OUT_DEPTH);
  assign issue_c     = en_q & ~in_empty_c & core_ready & ~flush_req_c &
                       (32'(inflight_q) < 32'(MAX_INFLIGHT)) & credit_c;

  // New words enter at the top so the first word ends up in the LSW
  assign in_shifted_c = (in_shift_q >> DATAWIDTH) |
                        (BLOCKWIDTH'(slave_writedata) << (BLOCKWIDTH - DATAWIDTH));
  assign in_last_c    = (in_idx_q == WIW'(WPB - 1));
  assign in_push_c    = wr_in_c & in_last_c & ~in_full_c;

  assign out_head_c   = out_mem[out_rptr_q];
  assign out_word_c   = DATAWIDTH'(out_head_c >> (32'(out_idx_q) * DATAWIDTH));
  assign out_last_c   = (out_idx_q == WIW'(WPB - 1));
  assign out_pop_c    = rd_out_c & ~out_empty_c & out_last_c;

  assign inflight_nxt_c = inflight_q + FW'(issue_c) - FW'(ret_c);
  assign flush_done_c   = flush_req_c & (inflight_nxt_c == '0);
  assign out_push_c     = ret_c & ~flush_done_c;

  // Next-state for all control, FIFO bookkeeping and registered outputs
  always_comb begin
    en_d        = en_q;
    mode_d      = mode_q;
    irq_en_d    = irq_en_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    in_shift_d  = in_shift_q;
    in_idx_d    = in_idx_q;
    in_wptr_d   = in_wptr_q;
    in_rptr_d   = in_rptr_q;
    out_wptr_d  = out_wptr_q;
    out_rptr_d  = out_rptr_q;
    out_idx_d   = out_idx_q;
    readdata_d  = readdata_q;
    core_data_d = core_data_q;
    core_valid_d = issue_c;
    inflight_d  = inflight_nxt_c;
    flush_d     = flush_req_c & ~flush_done_c;

    if (wr_in_c) begin
      in_shift_d = in_shifted_c;
      in_idx_d   = in_last_c ? '0 : in_idx_q + WIW'(1);
      if (in_last_c && in_full_c) ovf_d = 1'b1;
    end
    if (in_push_c) in_wptr_d = in_wptr_q + IPW'(1);
    if (issue_c) begin
      in_rptr_d   = in_rptr_q + IPW'(1);
      core_data_d = in_mem[in_rptr_q];
    end
    in_cnt_d = in_cnt_q + ICW'(in_push_c) - ICW'(issue_c);

    if (rd_out_c) begin
      if (out_empty_c) udf_d = 1'b1;
      else             out_idx_d = out_last_c ? '0 : out_idx_q + WIW'(1);
    end
    if (out_pop_c)  out_rptr_d = out_rptr_q + OPW'(1);
    if (out_push_c) out_wptr_d = out_wptr_q + OPW'(1);
    out_cnt_d = out_cnt_q + OCW'(out_push_c) - OCW'(out_pop_c);

    if (rd_c) begin
      case (slave_address)
        A_CTRL:      readdata_d = DATAWIDTH'({irq_en_q, mode_q, flush_q, en_q});
        A_STATUS:    readdata_d = DATAWIDTH'({udf_q, ovf_q, 2'b00, flush_q, busy_c,
                                              out_empty_c, out_full_c, in_empty_c, in_full_c});
        A_IN_COUNT:  readdata_d = DATAWIDTH'(in_cnt_q);
        A_OUT_COUNT: readdata_d = DATAWIDTH'(out_cnt_q);
        A_OUT_DATA:  readdata_d = out_empty_c ? '0 : out_word_c;
        default:     readdata_d = '0;
      endcase
    end

    if (wr_ctrl_c) begin
      en_d     = slave_writedata[0];
      mode_d   = slave_writedata[2];
      irq_en_d = slave_writedata[3];
    end
    if (wr_status_c) begin
      if (slave_writedata[8]) ovf_d = 1'b0;
      if (slave_writedata[9]) udf_d = 1'b0;
    end

    if (flush_done_c) begin
      in_shift_d = '0;
      in_idx_d   = '0;
      in_wptr_d  = '0;
      in_rptr_d  = '0;
      in_cnt_d   = '0;
      out_wptr_d = '0;
      out_rptr_d = '0;
      out_cnt_d  = '0;
      out_idx_d  = '0;
    end

    irq_d = irq_en_d & ((out_cnt_d != '0) | ovf_d | udf_d);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= 1'b0; mode_q <= 1'b0; irq_en_q <= 1'b0;
      flush_q <= 1'b0; ovf_q <= 1'b0; udf_q <= 1'b0;
      in_shift_q <= '0; in_idx_q <= '0; out_idx_q <= '0;
      in_wptr_q <= '0; in_rptr_q <= '0; in_cnt_q <= '0;
      out_wptr_q <= '0; out_rptr_q <= '0; out_cnt_q <= '0;
      inflight_q <= '0; readdata_q <= '0; core_data_q <= '0;
      core_valid_q <= 1'b0; irq_q <= 1'b0;
    end else begin
      en_q <= en_d; mode_q <= mode_d; irq_en_q <= irq_en_d;
      flush_q <= flush_d; ovf_q <= ovf_d; udf_q <= udf_d;
      in_shift_q <= in_shift_d; in_idx_q <= in_idx_d; out_idx_q <= out_idx_d;
      in_wptr_q <= in_wptr_d; in_rptr_q <= in_rptr_d; in_cnt_q <= in_cnt_d;
      out_wptr_q <= out_wptr_d; out_rptr_q <= out_rptr_d; out_cnt_q <= out_cnt_d;
      inflight_q <= inflight_d; readdata_q <= readdata_d; core_data_q <= core_data_d;
      core_valid_q <= core_valid_d; irq_q <= irq_d;
    end
  end

  // FIFO storage; stale entries are harmless because pointers are cleared
  always_ff @(posedge clk) begin
    if (in_push_c)  in_mem[in_wptr_q]   <= in_shifted_c;
    if (out_push_c) out_mem[out_wptr_q] <= core_data_out;
  end

  assign slave_readdata  = readdata_q;
  assign core_data_in    = core_data_q;
  assign core_valid_in   = core_valid_q;
  assign core_is_encrypt = mode_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_crypto_stream_bridge.sv
// Randomised bench for crypto_stream_bridge with a queue-based reference model.
module tb_crypto_stream_bridge;

  localparam int unsigned DW = 32, BW = 64, WPB = 2, IND = 16, OUTD = 16, MAXI = 4, AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic cs = 1'b0, sw = 1'b0, sr = 1'b0;
  logic [DW-1:0] wdata = '0, readdata;
  logic [BW-1:0] core_data_in, core_data_out = '0;
  logic core_valid_in, core_ready = 1'b1, core_is_encrypt, core_valid_out = 1'b0, irq;

  always #5 clk = ~clk;

  crypto_stream_bridge #(
    .DATAWIDTH(DW), .BLOCKWIDTH(BW), .IN_DEPTH(IND), .OUT_DEPTH(OUTD),
    .MAX_INFLIGHT(MAXI), .SLAVE_ADDRESSWIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .slave_address(addr), .slave_chipselect(cs),
    .slave_write(sw), .slave_writedata(wdata), .slave_read(sr), .slave_readdata(readdata),
    .core_data_in(core_data_in), .core_valid_in(core_valid_in), .core_ready(core_ready),
    .core_is_encrypt(core_is_encrypt), .core_data_out(core_data_out),
    .core_valid_out(core_valid_out), .irq(irq)
  );

  int n_cmp = 0, n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Core stand-in: echoes data+1 after a latency, in order
  logic [BW-1:0] pq[$];
  int pd[$];
  int cyc = 0, core_lat = 3, n_issue = 0;
  bit core_hold = 0, ready_rand = 0, lat_rand = 0;
  logic [BW-1:0] last_issue = '0;

  always @(negedge clk) begin
    if (core_valid_in === 1'b1) begin
      pq.push_back(core_data_in + 64'd1);
      pd.push_back(cyc + (lat_rand ? int'($urandom_range(1, 8)) : core_lat));
      n_issue++;
      last_issue = core_data_in;
    end
    core_valid_out = 1'b0;
    if (!core_hold && pq.size() > 0 && pd[0] <= cyc) begin
      core_valid_out = 1'b1;
      core_data_out  = pq.pop_front();
      void'(pd.pop_front());
    end
    core_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    cyc++;
  end

  // Reference model: FIFOs as queues, words as a list, counters as ints
  logic [BW-1:0] m_in_q[$], m_out_q[$];
  logic [DW-1:0] m_part[$];
  int m_oidx, m_inflight, t_insz;
  bit m_en, m_flush, m_mode, m_irqen, m_ovf, m_udf, m_ok = 0;
  bit t_wr, t_rd, t_fr, t_ret, t_iss, t_fdone;
  logic [DW-1:0] t_rv;
  logic [BW-1:0] t_blk;
  logic [BW-1:0] e_data;
  logic [DW-1:0] e_rd;
  bit e_valid, e_irq;

  always @(posedge clk) begin
    if (reset) begin
      m_in_q.delete(); m_out_q.delete(); m_part.delete();
      m_oidx = 0; m_inflight = 0;
      m_en = 0; m_flush = 0; m_mode = 0; m_irqen = 0; m_ovf = 0; m_udf = 0;
      e_valid = 0; e_data = '0; e_rd = '0; e_irq = 0; m_ok = 1;
    end else if (m_ok) begin
      t_wr  = cs && sw;
      t_rd  = cs && sr && !sw;
      t_fr  = m_flush || (t_wr && addr == 3'd0 && wdata[1]);
      t_ret = core_valid_out && m_inflight > 0;
      t_iss = m_en && m_in_q.size() > 0 && core_ready && !t_fr && m_inflight < MAXI &&
              (m_out_q.size() + m_inflight) < OUTD;
      if (t_rd) begin
        t_rv = '0;
        case (addr)
          3'd0: t_rv = DW'({m_irqen, m_mode, m_flush, m_en});
          3'd1: begin
            t_rv[0] = (m_in_q.size() == IND);
            t_rv[1] = (m_in_q.size() == 0);
            t_rv[2] = (m_out_q.size() == OUTD);
            t_rv[3] = (m_out_q.size() == 0);
            t_rv[4] = (m_inflight != 0);
            t_rv[5] = m_flush;
            t_rv[8] = m_ovf;
            t_rv[9] = m_udf;
          end
          3'd2: t_rv = DW'(m_in_q.size());
          3'd3: t_rv = DW'(m_out_q.size());
          3'd5: begin
            if (m_out_q.size() == 0) m_udf = 1;
            else begin
              t_rv = DW'(m_out_q[0] >> (m_oidx * DW));
              if (m_oidx == WPB - 1) begin void'(m_out_q.pop_front()); m_oidx = 0; end
              else m_oidx++;
            end
          end
          default: t_rv = '0;
        endcase
        e_rd = t_rv;
      end
      t_insz = m_in_q.size();
      if (t_iss) e_data = m_in_q.pop_front();
      e_valid = t_iss;
      if (t_wr && addr == 3'd4) begin
        m_part.push_back(wdata);
        if (m_part.size() == WPB) begin
          t_blk = '0;
          foreach (m_part[i]) t_blk |= BW'(m_part[i]) << (i * DW);
          m_part.delete();
          if (t_insz == IND) m_ovf = 1;
          else m_in_q.push_back(t_blk);
        end
      end
      if (t_ret) m_out_q.push_back(core_data_out);
      m_inflight = m_inflight + int'(t_iss) - int'(t_ret);
      t_fdone = t_fr && m_inflight == 0;
      if (t_fdone) begin m_in_q.delete(); m_out_q.delete(); m_part.delete(); m_oidx = 0; end
      m_flush = t_fr && !t_fdone;
      if (t_wr && addr == 3'd0) begin m_en = wdata[0]; m_mode = wdata[2]; m_irqen = wdata[3]; end
      if (t_wr && addr == 3'd1) begin
        if (wdata[8]) m_ovf = 0;
        if (wdata[9]) m_udf = 0;
      end
      e_irq = m_irqen && (m_out_q.size() > 0 || m_ovf || m_udf);
    end
  end

  // Per-cycle comparison of every registered output against the model
  always @(negedge clk) begin
    if (m_ok) begin
      chk("core_valid_in", 64'(core_valid_in), 64'(e_valid));
      chk("core_data_in", core_data_in, e_data);
      chk("slave_readdata", 64'(readdata), 64'(e_rd));
      chk("irq", 64'(irq), 64'(e_irq));
      chk("core_is_encrypt", 64'(core_is_encrypt), 64'(m_mode));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_fail=%0d", n_cmp, n_fail);
    $fatal(1);
  end

  // One bus cycle, entered and left at a falling edge
  task automatic bus(input bit c, input bit w, input bit r, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output logic [DW-1:0] q);
    cs = c; sw = w; sr = r; addr = a; wdata = d;
    @(negedge clk);
    q = readdata;
    cs = 0; sw = 0; sr = 0;
  endtask

  task automatic bwr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] q;
    bus(1'b1, 1'b1, 1'b0, a, d, q);
  endtask

  task automatic brd(input logic [AW-1:0] a, output logic [DW-1:0] q);
    bus(1'b1, 1'b0, 1'b1, a, '0, q);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input bit clr);
    reset = 1;
    idle(2);
    reset = 0;
    if (clr) begin pq.delete(); pd.delete(); end
  endtask

  task automatic push_blk(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    bwr(3'd4, lo);
    bwr(3'd4, hi);
  endtask

  task automatic wait_issues(input int n, input int budget);
    int k = 0;
    while (n_issue < n && k < budget) begin @(negedge clk); k++; end
    chk("issue_wait", 64'(n_issue), 64'(n));
  endtask

  logic [DW-1:0] v;
  int r_op, k;

  initial begin
    idle(3);
    reset = 0;

    // Single block round trip
    do_reset(1);
    brd(3'd1, v); chk("reset_status", 64'(v), 64'h0A);
    n_issue = 0; core_lat = 3;
    bwr(3'd0, 32'h5);
    push_blk(32'h89ABCDEF, 32'h01234567);
    wait_issues(1, 10);
    chk("t1_core_data_in", last_issue, 64'h0123456789ABCDEF);
    chk("t1_mode", 64'(core_is_encrypt), 64'h1);
    idle(10);
    brd(3'd3, v); chk("t1_out_count", 64'(v), 64'd1);
    brd(3'd5, v); chk("t1_out_w0", 64'(v), 64'h89ABCDF0);
    brd(3'd5, v); chk("t1_out_w1", 64'(v), 64'h01234567);
    brd(3'd1, v); chk("t1_out_empty", 64'(v[3]), 64'd1);

    // Overflow with EN=0
    do_reset(1);
    for (int i = 0; i < 17; i++) push_blk(DW'(i), DW'(i + 100));
    brd(3'd2, v); chk("t2_in_count", 64'(v), 64'd16);
    chk("t2_model_in_count", 64'(m_in_q.size()), 64'd16);
    brd(3'd1, v); chk("t2_ovf_set", 64'(v[8]), 64'd1);
    bwr(3'd1, 32'h100);
    brd(3'd1, v); chk("t2_ovf_clr", 64'(v[8]), 64'd0);

    // Credit limit: core never returns
    do_reset(1);
    core_hold = 1; n_issue = 0;
    for (int i = 0; i < 8; i++) push_blk($urandom, $urandom);
    bwr(3'd0, 32'h1);
    idle(20);
    chk("t3_issues", 64'(n_issue), 64'd4);
    brd(3'd1, v); chk("t3_busy", 64'(v[4]), 64'd1);
    brd(3'd2, v); chk("t3_in_count", 64'(v), 64'd4);
    core_hold = 0;
    idle(30);

    // Credit limit with 14 results already waiting
    do_reset(1);
    bwr(3'd0, 32'h1);
    for (int i = 0; i < 14; i++) push_blk($urandom, $urandom);
    idle(60);
    brd(3'd3, v); chk("t3b_out_count", 64'(v), 64'd14);
    core_hold = 1; n_issue = 0;
    for (int i = 0; i < 4; i++) push_blk($urandom, $urandom);
    idle(20);
    chk("t3b_issues", 64'(n_issue), 64'd2);
    brd(3'd2, v); chk("t3b_in_count", 64'(v), 64'd2);
    core_hold = 0;
    idle(20);

    // Underflow and irq
    do_reset(1);
    bwr(3'd0, 32'h8);
    brd(3'd5, v); chk("t4_underflow_data", 64'(v), 64'd0);
    brd(3'd1, v); chk("t4_udf_set", 64'(v[9]), 64'd1);
    brd(3'd3, v); chk("t4_out_count", 64'(v), 64'd0);
    chk("t4_irq", 64'(irq), 64'd1);

    // Flush with three results in flight
    do_reset(1);
    core_lat = 20; n_issue = 0;
    bwr(3'd0, 32'h1);
    for (int i = 0; i < 3; i++) push_blk($urandom, $urandom);
    wait_issues(3, 20);
    bwr(3'd4, 32'hDEAD0000);
    bwr(3'd0, 32'h3);
    brd(3'd1, v); chk("t5_flush_pending", 64'(v[5]), 64'd1);
    k = 0;
    while (v[5] && k < 100) begin brd(3'd1, v); k++; end
    chk("t5_flush_cleared", 64'(v[5]), 64'd0);
    brd(3'd0, v); chk("t5_ctrl_flush_bit", 64'(v[1]), 64'd0);
    brd(3'd2, v); chk("t5_in_count", 64'(v), 64'd0);
    brd(3'd3, v); chk("t5_out_count", 64'(v), 64'd0);
    bwr(3'd0, 32'h0);
    push_blk(32'h11111111, 32'h22222222);
    bwr(3'd0, 32'h1);
    wait_issues(4, 10);
    chk("t5_fresh_block", last_issue, 64'h2222222211111111);
    idle(30);

    // Reset mid-stream; stale results must be ignored
    do_reset(1);
    core_lat = 15; n_issue = 0;
    bwr(3'd0, 32'h1);
    push_blk(32'hAAAA0001, 32'hAAAA0002);
    push_blk(32'hBBBB0001, 32'hBBBB0002);
    wait_issues(2, 10);
    bwr(3'd4, 32'hCCCC0001);
    do_reset(0);
    idle(30);
    brd(3'd3, v); chk("t6_out_count", 64'(v), 64'd0);
    brd(3'd2, v); chk("t6_in_count", 64'(v), 64'd0);
    push_blk(32'h33333333, 32'h44444444);
    brd(3'd2, v); chk("t6_in_count_new", 64'(v), 64'd1);
    bwr(3'd0, 32'h1);
    wait_issues(3, 10);
    chk("t6_fresh_block", last_issue, 64'h4444444433333333);
    idle(30);

    // Random traffic against the model
    do_reset(1);
    lat_rand = 1; ready_rand = 1;
    bwr(3'd0, 32'h9);
    for (int it = 0; it < 3000; it++) begin
      r_op = int'($urandom_range(0, 99));
      if (r_op < 35)      bus(1'b1, 1'b1, $urandom_range(0, 7) == 0, 3'd4, $urandom, v);
      else if (r_op < 55) bus(1'b1, 1'b0, 1'b1, 3'd5, '0, v);
      else if (r_op < 65) bus(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)), '0, v);
      else if (r_op < 72) bus(1'b1, 1'b1, 1'b0, 3'd0,
                              {28'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) != 0)}, v);
      else if (r_op < 76) bus(1'b1, 1'b1, 1'b0, 3'd1, $urandom & 32'h300, v);
      else if (r_op < 78) bus(1'b1, 1'b1, 1'b0, 3'($urandom_range(6, 7)), $urandom, v);
      else if (r_op < 82) bus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, v);
      else if (r_op < 83) do_reset(0);
      else idle(1);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
